// File: rtl/mdu_ex_if.sv
// EX-stage <-> MDU bundle: decoded op and forwarded operands in; busy/stall and HI/LO back.
// The pipeline side drives the master modport and the MDU takes the slave modport.
interface mdu_ex_if;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        HWInt;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, rs_e, rt_e, HWInt,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, mdop, rs_e, rt_e, HWInt,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_ex.sv
// Multi-cycle mult/div unit owning HI/LO; madd/maddu only with MDU_MADD_EN defined.
// Accept -> busy for N cycles, HI/LO written on the last edge; stall_req backpressures ID while running.
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    mdu_ex_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, r_hi, r_lo;

    logic        w_long, w_accept, w_load, w_wr;
    logic [31:0] w_hi_nxt, w_lo_nxt;

    logic        w_sgn, w_neg_a, w_neg_b;
    logic [63:0] w_ma, w_mb, w_prod;
    logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur, w_quo, w_rem;

    always_comb begin
        w_long = 1'b0;
        case (bus.mdop)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_long = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  w_long = 1'b1;
`endif
            default:                            w_long = 1'b0;
        endcase
    end

    assign w_accept      = (r_state == S_IDLE) && bus.start && !bus.HWInt;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.stall_req = bus.busy | (bus.start & w_long & ~bus.HWInt);
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

    // One shared datapath: the low 64 bits of a sign/zero-extended product serve both mult flavours.
    assign w_sgn   = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD);
    assign w_ma    = {{32{w_sgn & r_a[31]}}, r_a};
    assign w_mb    = {{32{w_sgn & r_b[31]}}, r_b};
    assign w_prod  = w_ma * w_mb;

    assign w_neg_a = w_sgn & r_a[31];
    assign w_neg_b = w_sgn & r_b[31];
    assign w_abs_a = w_neg_a ? (32'd0 - r_a) : r_a;
    assign w_abs_b = w_neg_b ? (32'd0 - r_b) : r_b;
    assign w_uq    = w_abs_a / w_abs_b;
    assign w_ur    = w_abs_a % w_abs_b;
    assign w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_rem   = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_wr        = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_long) begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                        w_cnt_nxt   = (bus.mdop == OP_DIV || bus.mdop == OP_DIVU) ? DIV_LAST : MULT_LAST;
                    end else if (bus.mdop == OP_MTHI) begin
                        w_wr     = 1'b1;
                        w_hi_nxt = bus.rs_e;
                    end else if (bus.mdop == OP_MTLO) begin
                        w_wr     = 1'b1;
                        w_lo_nxt = bus.rs_e;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_IDLE;
                    case (r_op)
                        OP_MULT, OP_MULTU: begin
                            w_wr                 = 1'b1;
                            {w_hi_nxt, w_lo_nxt} = w_prod;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero burns the full latency but leaves HI/LO alone.
                            w_wr     = (r_b != 32'd0);
                            w_hi_nxt = w_rem;
                            w_lo_nxt = w_quo;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            w_wr                 = 1'b1;
                            {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod;
                        end
`endif
                        default: w_wr = 1'b0;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_op <= bus.mdop;
                r_a  <= bus.rs_e;
                r_b  <= bus.rt_e;
            end
            if (w_wr) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ex.sv
// Directed-vector bench for mdu_ex with hand-computed results.
module tb_mdu_ex;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   nb;
    logic sr;

    mdu_ex_if bus();

    mdu_ex #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op for one cycle, sample stall_req in that cycle, then count busy cycles.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, output logic stall, output int nbusy);
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = op; bus.rs_e = a; bus.rt_e = b; bus.HWInt = hw;
        #1 stall = bus.stall_req;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0; bus.HWInt = 1'b0;
        nbusy = 0;
        while (bus.busy && nbusy < 64) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mdop = 4'd0; bus.rs_e = 32'd0; bus.rt_e = 32'd0; bus.HWInt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, sr, nb);
        check("mult_stall", 64'(sr), 64'd1);
        check("mult_busy", 64'(nb), 64'd5);
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);

        do_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, sr, nb);
        check("multu_busy", 64'(nb), 64'd5);
        check("multu_hilo", {bus.hi, bus.lo}, 64'h00000002_FFFFFFFA);

        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, sr, nb);
        check("div_busy", 64'(nb), 64'd10);
        check("div_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);

        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, sr, nb);
        check("div_ovf_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);

        do_op(4'd4, 32'd1234, 32'd0, 1'b0, sr, nb);
        check("divu0_busy", 64'(nb), 64'd10);
        check("divu0_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 4'd5; bus.rs_e = 32'h12345678;
        #1 check("mthi_stall", 64'(bus.stall_req), 64'd0);
        @(negedge clk);
        check("mthi_hilo", {bus.hi, bus.lo}, 64'h12345678_80000000);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.mdop = 4'd6; bus.rs_e = 32'h9ABCDEF0;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0;
        check("mtlo_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);

        do_op(4'd5, 32'hDEADBEEF, 32'd0, 1'b1, sr, nb);
        do_op(4'd6, 32'hCAFEF00D, 32'd0, 1'b1, sr, nb);
        check("mt_hwint_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);

        do_op(4'd3, 32'd100, 32'd7, 1'b1, sr, nb);
        check("div_hwint_stall", 64'(sr), 64'd0);
        check("div_hwint_busy", 64'(nb), 64'd0);
        check("div_hwint_hilo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);

        // mult 7*6 with HWInt and a competing div start in the 2nd busy cycle
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 4'd1; bus.rs_e = 32'd7; bus.rt_e = 32'd6;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0;
        @(negedge clk);
        bus.HWInt = 1'b1; bus.start = 1'b1; bus.mdop = 4'd3; bus.rs_e = 32'd100; bus.rt_e = 32'd3;
        #1 check("run_stall", 64'(bus.stall_req), 64'd1);
        @(negedge clk);
        bus.HWInt = 1'b0; bus.start = 1'b0; bus.mdop = 4'd0;
        nb = 2;
        while (bus.busy && nb < 64) begin
            nb++;
            @(negedge clk);
        end
        check("mult_hw_busy", 64'(nb), 64'd5);
        check("mult_hw_hilo", {bus.hi, bus.lo}, 64'h00000000_0000002A);

        // async reset in the 3rd busy cycle of a div
        do_op(4'd5, 32'h00000055, 32'd0, 1'b0, sr, nb);
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 4'd3; bus.rs_e = 32'd100; bus.rt_e = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        check("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);

        do_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, sr, nb);
        do_op(4'd8, 32'd1, 32'd1, 1'b0, sr, nb);
`ifdef MDU_MADD_EN
        check("maddu_stall", 64'(sr), 64'd1);
        check("maddu_busy", 64'(nb), 64'd5);
        check("maddu_hilo", {bus.hi, bus.lo}, 64'h00000001_00000000);
`else
        check("maddu_stall", 64'(sr), 64'd0);
        check("maddu_busy", 64'(nb), 64'd0);
        check("maddu_hilo", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_ex.md
# mdu_ex

Multiply/divide unit in the EX stage. It consumes the operands and decoded op delivered by the ID/EX pipeline register and owns the architectural HI/LO registers. Operations run over a fixed number of cycles and raise `busy`; the hazard unit uses `busy`/`stall_req` to freeze ID and clear ID/EX. HI/LO are read combinationally by the EX stage for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd/maddu); legal range 1..31.
- `DIV_CYCLES`, 10, busy cycles for div/divu; legal range 1..31.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX-stage instruction is an MDU op this cycle.
- `mdop`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; other codes are no-ops.
- `rs_e`  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- `rt_e`  in  32  forwarded rt operand.
- `HWInt`  in  1  interrupt/exception taken this cycle; blocks acceptance.
- `busy`  out  1  registered; high while an operation runs.
- `stall_req`  out  1  combinational: `busy | (start & mdop in {1,2,3,4,7,8} & !HWInt)`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, RUN. 5-bit down-counter `cnt`.
- Accept condition: state IDLE, `start=1`, `HWInt=0`.
- mult/multu/div/divu/madd/maddu accepted: capture `rs_e`, `rt_e`, op; go to RUN; `cnt <= N-1` (N = MULT_CYCLES or DIV_CYCLES).
- RUN: `cnt` decrements each cycle; at `cnt==0` the edge writes HI/LO and returns to IDLE.
- mthi/mtlo accepted: write `rs_e` into HI/LO at that edge; no RUN, `busy` stays 0.
- `start` while RUN: ignored (the hazard unit holds it stalled; it re-presents after `busy` falls).
- `HWInt=1`: blocks acceptance of any op, including mthi/mtlo. An operation already in RUN completes normally.
- mult: signed 32x32 -> 64, `{hi,lo}` = product. multu: unsigned.
- div: `lo` = quotient truncated toward zero, `hi` = remainder with dividend's sign. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu: unsigned.
- Divide by zero: full DIV_CYCLES of busy, HI/LO unchanged at completion.
- madd/maddu: `{hi,lo} <= {hi,lo} + product` (signed/unsigned product, 64-bit wraparound), using HI/LO as of the completion edge.

## Timing
- Reset: state IDLE, `cnt=0`, `busy=0`, `hi=0`, `lo=0`. Asserting reset mid-operation discards the operation immediately.
- Accept at edge T -> `busy=1` during cycles T+1..T+N; edge T+N writes HI/LO and clears `busy`. New HI/LO are visible in the first cycle `busy` is 0.
- `stall_req` is high in the accept cycle and all N busy cycles (N+1 cycles).
- Back-to-back: a new op can be accepted in the first cycle `busy` is 0; with madd it uses the freshly written HI/LO.
- mthi/mtlo: HI/LO update at the accepting edge; visible next cycle.

## Configuration
- `MDU_MADD_EN` defined: mdop 7/8 (madd/maddu) supported as above.
- Not defined: mdop 7/8 are no-ops. Nothing is accepted, `stall_req` excludes them, and no madd adder is synthesized.

## Test plan
- Reset, then mult rs=0xFFFFFFFE (-2), rt=3 -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu by 0 -> HI/LO unchanged.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo update one edge each with `busy`=0. Same ops with HWInt=1 -> no change.
- start div with HWInt=1 -> `busy` stays 0, `stall_req`=0. Assert HWInt in the 2nd busy cycle of a mult -> mult completes with the correct result.
- Reset asserted asynchronously in the 3rd busy cycle of a div -> `busy`, hi, lo go to 0 immediately, without waiting for a clock edge. A second start during RUN is ignored.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1 -> hi=1, lo=0. Without it: same stimulus -> no busy, HI/LO unchanged.
